// File: rtl/dest_tracker.sv
// Destination-register tracker for a 5-stage pipeline: follows the EX/MEM/WB
// write destinations and derives load-use stall, forwarding selects and WB write port.
module dest_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [4:0] issue_rtd,
  input  logic       issue_regwrite,
  input  logic       issue_memtoreg,
  input  logic       flush,
  input  logic [4:0] src_rs,
  input  logic [4:0] src_rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       wb_we,
  output logic [4:0] wb_addr,
  output logic [1:0] pending
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rtd;
    logic       regwrite;
    logic       memtoreg;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  slot_t ex_q, mem_q, wb_q;

  // Register 0 is hard-wired, so a slot targeting it never counts as a writer.
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rtd == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic [4:0] src, input logic use_src);
    if (!use_src)            return SEL_RF;
    if (writes(ex, src))     return ex.memtoreg ? SEL_RF : SEL_EX;
    if (writes(mem, src))    return SEL_MEM;
    if (writes(wb, src))     return SEL_WB;
    return SEL_RF;
  endfunction

  logic ex_load_hit;
  logic ex_cnt, mem_cnt, wb_cnt;

  always_comb begin
    ex_load_hit = ex_q.memtoreg &&
                  ((use_rs && writes(ex_q, src_rs)) || (use_rt && writes(ex_q, src_rt)));
    stall       = ex_load_hit;
    fwd_rs      = fwd_sel(ex_q, mem_q, wb_q, src_rs, use_rs);
    fwd_rt      = fwd_sel(ex_q, mem_q, wb_q, src_rt, use_rt);
    wb_we       = writes(wb_q, wb_q.rtd);
    wb_addr     = wb_we ? wb_q.rtd : 5'd0;
    ex_cnt      = writes(ex_q, ex_q.rtd);
    mem_cnt     = writes(mem_q, mem_q.rtd);
    wb_cnt      = writes(wb_q, wb_q.rtd);
    pending     = {1'b0, ex_cnt} + {1'b0, mem_cnt} + {1'b0, wb_cnt};
  end

  // NOTE: state registers use non-blocking assignments so every slot samples
  // the pre-edge value of its neighbour; blocking here would collapse the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      // A stall and a flush in the same cycle still yield a single bubble.
      if (stall || flush)
        ex_q <= '0;
      else
        ex_q <= '{valid: issue_valid, rtd: issue_rtd,
                  regwrite: issue_regwrite, memtoreg: issue_memtoreg};
    end
  end

endmodule

// File: tb/tb_dest_tracker.sv
// Directed bench for dest_tracker: expected outputs are queued with each
// stimulus step and popped for comparison once the outputs have settled.
module tb_dest_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_regwrite, issue_memtoreg, flush;
  logic [4:0] issue_rtd, src_rs, src_rt;
  logic       use_rs, use_rt;
  logic       stall, wb_we;
  logic [1:0] fwd_rs, fwd_rt, pending;
  logic [4:0] wb_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       wb_we;
    logic [4:0] wb_addr;
    logic [1:0] pending;
  } exp_t;

  exp_t sb_q[$];

  dest_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rtd(issue_rtd),
    .issue_regwrite(issue_regwrite), .issue_memtoreg(issue_memtoreg),
    .flush(flush), .src_rs(src_rs), .src_rt(src_rt),
    .use_rs(use_rs), .use_rt(use_rt),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .wb_we(wb_we), .wb_addr(wb_addr), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge, far from the sampling edge.
  task automatic drive(input logic v, input logic [4:0] rtd, input logic rw, input logic mtr,
                       input logic fl, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt);
    @(negedge clk);
    issue_valid = v; issue_rtd = rtd; issue_regwrite = rw; issue_memtoreg = mtr;
    flush = fl; src_rs = rs; use_rs = urs; src_rt = rt; use_rt = urt;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic expect_o(input logic st, input logic [1:0] frs, input logic [1:0] frt,
                          input logic we, input logic [4:0] wa, input logic [1:0] pend);
    sb_q.push_back('{stall: st, fwd_rs: frs, fwd_rt: frt, wb_we: we, wb_addr: wa, pending: pend});
  endtask

  task automatic check_outs(input string tag);
    exp_t e;
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".stall"},   {7'd0, stall},   {7'd0, e.stall});
    check({tag, ".fwd_rs"},  {6'd0, fwd_rs},  {6'd0, e.fwd_rs});
    check({tag, ".fwd_rt"},  {6'd0, fwd_rt},  {6'd0, e.fwd_rt});
    check({tag, ".wb_we"},   {7'd0, wb_we},   {7'd0, e.wb_we});
    check({tag, ".wb_addr"}, {3'd0, wb_addr}, {3'd0, e.wb_addr});
    check({tag, ".pending"}, {6'd0, pending}, {6'd0, e.pending});
  endtask

  initial begin
    // Reset with a writer on the issue port: it must be ignored.
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(); rst_n = 1'b1;
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("reset");

    // ALU chain on R8: EX, then MEM, then WB forwarding.
    drive(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("alu_issue");
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
    expect_o(0, 2'b01, 2'b00, 0, 5'd0, 2'd1); check_outs("alu_ex");
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
    expect_o(0, 2'b10, 2'b00, 0, 5'd0, 2'd1); check_outs("alu_mem");
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
    expect_o(0, 2'b11, 2'b00, 1, 5'd8, 2'd1); check_outs("alu_wb");

    // Load-use on R9 through rt; consumer writes R4.
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("lw_issue");
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    expect_o(1, 2'b00, 2'b00, 0, 5'd0, 2'd1); check_outs("lu_stall");
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    expect_o(0, 2'b00, 2'b10, 0, 5'd0, 2'd1); check_outs("lu_release");
    idle();
    expect_o(0, 2'b00, 2'b00, 1, 5'd9, 2'd2); check_outs("lu_wb");
    idle();
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd1); check_outs("lu_drain1");
    idle();
    expect_o(0, 2'b00, 2'b00, 1, 5'd4, 2'd1); check_outs("lu_drain2");

    // R5 in all three slots: youngest wins; use_rt=0 gates fwd_rt.
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("prio_fill1");
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0);
    expect_o(0, 2'b01, 2'b00, 1, 5'd5, 2'd3); check_outs("prio_ex");
    // A load targeting R0 sits in EX: no stall, no forward, not pending.
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b1);
    expect_o(0, 2'b10, 2'b00, 1, 5'd5, 2'd2); check_outs("prio_r0");
    idle();
    idle();
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("r0_in_wb");

    // Flush squashes the R10 writer.
    drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("flush");

    // Reset while a load-use stall is active.
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    rst_n = 1'b0;
    expect_o(1, 2'b00, 2'b00, 1, 5'd1, 2'd3); check_outs("pre_reset");
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    rst_n = 1'b1;
    expect_o(0, 2'b00, 2'b00, 0, 5'd0, 2'd0); check_outs("post_reset");

    // Flush+stall together: a load in EX hides the older MEM match on R6.
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
    expect_o(1, 2'b00, 2'b00, 0, 5'd0, 2'd2); check_outs("fs_stall");
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    expect_o(0, 2'b10, 2'b00, 1, 5'd6, 2'd2); check_outs("fs_release");
    idle();
    expect_o(0, 2'b00, 2'b00, 1, 5'd6, 2'd2); check_outs("fs_load_wb");

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_tracker.md
DEST_TRACKER -- requirements
Module: dest_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; reset is sampled only on the rising clock edge.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 issue_valid  input  1  decode stage presents an instruction this cycle.
REQ-005 issue_rtd  input  5  selected write-destination register (rt or rd) of the issuing instruction.
REQ-006 issue_regwrite  input  1  issuing instruction writes the register file.
REQ-007 issue_memtoreg  input  1  issuing instruction is a load (result available only after MEM).
REQ-008 flush  input  1  squash the instruction entering EX this cycle.
REQ-009 src_rs, src_rt  input  5 each  decode-stage source register numbers.
REQ-010 use_rs, use_rt  input  1 each  decode instruction actually reads that source.
REQ-011 stall  output  1  hold decode/fetch; insert bubble into EX.
REQ-012 fwd_rs, fwd_rt  output  2 each  operand source select: 00 register file, 01 EX slot, 10 MEM slot, 11 WB slot.
REQ-013 wb_we  output  1  register-file write enable for the WB slot.
REQ-014 wb_addr  output  5  register-file write address for the WB slot.
REQ-015 pending  output  2  count of valid in-flight writes across EX, MEM, WB (0-3).

Function
REQ-016 The block SHALL hold three slots, EX, MEM, WB, each storing valid, rtd[4:0], regwrite, memtoreg.
REQ-017 Each rising edge (rst_n=1): WB <= MEM, MEM <= EX, EX <= {issue_valid, issue_rtd, issue_regwrite, issue_memtoreg}.
REQ-018 When stall=1 or flush=1 at an edge, EX SHALL instead load a bubble (all fields 0); MEM and WB still advance.
REQ-019 flush and stall asserted together SHALL produce exactly one bubble; no other difference.
REQ-020 A slot "writes R" iff valid=1, regwrite=1, rtd=R, and R!=0; register 0 SHALL never match, forward, or stall.
REQ-021 stall SHALL be combinational: 1 iff the EX slot writes R, EX.memtoreg=1, and ((use_rs and src_rs=R) or (use_rt and src_rt=R)); otherwise 0.
REQ-022 fwd_rs SHALL be 01 if EX writes src_rs and EX is not a load; else 10 if MEM writes src_rs; else 11 if WB writes src_rs; else 00. Youngest match wins.
REQ-023 A load in EX matching src_rs SHALL block older matches: fwd_rs=00 while stall=1.
REQ-024 fwd_rt SHALL follow REQ-022/023 with src_rt; use_rs/use_rt=0 forces the corresponding fwd output to 00.
REQ-025 wb_we SHALL be 1 iff WB.valid=1, WB.regwrite=1, WB.rtd!=0; wb_addr SHALL equal WB.rtd whenever wb_we=1 and 0 otherwise.
REQ-026 pending SHALL equal the number of slots with valid=1 and regwrite=1 and rtd!=0, combinationally from current slot state.
REQ-027 Stall latency: a load-use pair stalls exactly one cycle; the next cycle the load sits in MEM and fwd selects 10.
REQ-028 All outputs SHALL be combinational functions of slot state and current inputs; no output registers.

Reset
REQ-029 rst_n=0 at an edge SHALL clear all three slots to bubbles regardless of issue_valid, flush, or stall.
REQ-030 After reset: stall=0, fwd_rs=fwd_rt=00, wb_we=0, wb_addr=0, pending=0 (given use_rs=use_rt=0).
REQ-031 Reset asserted mid-stall SHALL drop the in-flight load; the first cycle after release SHALL show stall=0.

Verification
REQ-032 ALU chain: issue add to R8; next cycle src_rs=8, use_rs=1 -> fwd_rs=01, stall=0; one cycle later (no new R8 writer) -> 10; then -> 11, wb_we=1, wb_addr=8.
REQ-033 Load-use: issue lw to R9 (memtoreg=1); next cycle src_rt=9, use_rt=1 -> stall=1, fwd_rt=00; following cycle -> stall=0, fwd_rt=10.
REQ-034 Priority: writes to R5 in WB, MEM, and EX (non-load) simultaneously, src_rs=5 -> fwd_rs=01; src_rt=0 with R0 writer in EX -> fwd_rt=00, stall=0.
REQ-035 Flush: issue add R10 with flush=1 -> next cycle EX empty, pending excludes it; src_rs=10 -> fwd_rs=00.
REQ-036 Reset mid-pipe: three valid writers to R1,R2,R3 (pending=3); rst_n=0 one edge -> pending=0, wb_we=0, stall=0.
REQ-037 Flush+stall together during load-use -> exactly one bubble; load reaches WB with wb_we=1 two edges later.
